// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer.
// Per-channel FSM state encodings.
package debounce_pkg;

  typedef enum logic [1:0] {
    WAIT_ON_CHANGE = 2'b00,
    CHANGE_STATE   = 2'b01
  } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, change-confirm FSM and long-press timer.
// Each edge output is a registered one-cycle pulse.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_TIME   = 1000,
  parameter int LONG_PRESS_TIME = 500000,
  parameter int CNT_W           = 20,
  parameter int HOLD_W          = 20,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic debounced_out,
  output logic rise_out,
  output logic fall_out,
  output logic long_out
);

  // Counters top out at their thresholds, so each threshold must fit its counter.
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
    $error("debounce_channel: SYNC_STAGES must be 2..4");
  end
  if ((DEBOUNCE_TIME < 0) || (longint'(DEBOUNCE_TIME) >= (longint'(1) << CNT_W))) begin : g_bad_cnt
    $error("debounce_channel: CNT_W too narrow for DEBOUNCE_TIME");
  end
  if ((LONG_PRESS_TIME < 1) || (longint'(LONG_PRESS_TIME) >= (longint'(1) << HOLD_W))) begin : g_bad_hold
    $error("debounce_channel: HOLD_W too narrow for LONG_PRESS_TIME");
  end

  localparam logic [CNT_W-1:0]  DT_C     = CNT_W'(DEBOUNCE_TIME);
  localparam logic [HOLD_W-1:0] LPT_C    = HOLD_W'(LONG_PRESS_TIME);
  localparam logic [HOLD_W-1:0] LPT_M1_C = HOLD_W'(LONG_PRESS_TIME - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  db_state_e              r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [HOLD_W-1:0]      r_hold;
  logic                   r_out;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_long;

  logic                   w_sync;
  db_state_e              w_state_next;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [HOLD_W-1:0]      w_hold_next;
  logic                   w_out_next;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_long;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync  <= '0;
      r_state <= WAIT_ON_CHANGE;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_out   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], button_in};
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_hold  <= w_hold_next;
      r_out   <= w_out_next;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_long  <= w_long;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_out_next   = r_out;
    case (r_state)
      WAIT_ON_CHANGE: begin
        if (w_sync != r_out) begin
          w_state_next = CHANGE_STATE;
          w_cnt_next   = '0;
        end
      end
      CHANGE_STATE: begin
        if (w_sync == r_out) begin
          w_state_next = WAIT_ON_CHANGE;
        end else if (r_cnt >= DT_C) begin
          w_out_next   = w_sync;
          w_state_next = WAIT_ON_CHANGE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = WAIT_ON_CHANGE;
    endcase
  end

  // Hold counter saturates, so the long-press match fires once per press.
  always_comb begin
    w_rise = ~r_out & w_out_next;
    w_fall = r_out & ~w_out_next;
    w_hold_next = r_hold;
    if (!r_out) begin
      w_hold_next = '0;
    end else if (r_hold != LPT_C) begin
      w_hold_next = r_hold + 1'b1;
    end
    w_long = r_out & (r_hold == LPT_M1_C) & ~w_fall;
  end

  assign debounced_out = r_out;
  assign rise_out      = r_rise;
  assign fall_out      = r_fall;
  assign long_out      = r_long;

endmodule

// File: rtl/multi_debouncer.sv
// Array of independent debounce channels sharing clock and reset.
module multi_debouncer #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_TIME   = 1000,
  parameter int LONG_PRESS_TIME = 500000,
  parameter int CNT_W           = 20,
  parameter int HOLD_W          = 20,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] button_in,
  output logic [NUM_CH-1:0] debounced_out,
  output logic [NUM_CH-1:0] rise_out,
  output logic [NUM_CH-1:0] fall_out,
  output logic [NUM_CH-1:0] long_out
);

  if ((NUM_CH < 1) || (NUM_CH > 32)) begin : g_bad_num_ch
    $error("multi_debouncer: NUM_CH must be 1..32");
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_TIME  (DEBOUNCE_TIME),
      .LONG_PRESS_TIME(LONG_PRESS_TIME),
      .CNT_W          (CNT_W),
      .HOLD_W         (HOLD_W),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .button_in    (button_in[gi]),
      .debounced_out(debounced_out[gi]),
      .rise_out     (rise_out[gi]),
      .fall_out     (fall_out[gi]),
      .long_out     (long_out[gi])
    );
  end

endmodule
